// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU, single-cycle ops plus optional WIDTH-cycle shift-add multiply.
// Define ALU_MC_MUL_EN to build the MUL datapath/state; otherwise op 9 is illegal.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_overflow,
    output logic             illegal_op
);
    localparam int SHW = $clog2(WIDTH);

`ifdef ALU_MC_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    state_t state, state_n;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum, diff, rot, res;
    logic             ovf, ill;

    assign sh        = src2[SHW-1:0];
    assign sum       = src1 + src2;
    assign diff      = src1 - src2;
    assign rot       = WIDTH'({src1, src1} >> sh);
    assign in_ready  = state == IDLE;
    assign out_valid = state == HOLD;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        ill = 1'b0;
        case (op)
            4'd0: begin
                res = sum;
                ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            4'd1: begin
                res = diff;
                ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
            end
            4'd2:    res = src1 & src2;
            4'd3:    res = src1 | src2;
            4'd4:    res = src1 ^ src2;
            4'd5:    res = src1 >> sh;
            4'd6:    res = src1 << sh;
            4'd7:    res = rot;
            4'd8:    res = src1;
            default: ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [WIDTH:0]     psum;

    // acc holds {partial product, remaining multiplier bits}; one bit retires per cycle
    assign psum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_n = {psum, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (state == IDLE && in_valid && op == 4'd9) begin
            cnt   <= '0;
            mcand <= src1;
            acc   <= {{WIDTH{1'b0}}, src2};
        end else if (state == MUL) begin
            cnt <= cnt + 1'b1;
            acc <= acc_n;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
`ifdef ALU_MC_MUL_EN
            IDLE:    if (in_valid) state_n = op == 4'd9 ? MUL : HOLD;
            MUL:     if (&cnt) state_n = HOLD;
`else
            IDLE:    if (in_valid) state_n = HOLD;
`endif
            HOLD:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_result   <= '0;
            alu_overflow <= 1'b0;
            illegal_op   <= 1'b0;
        end else if (state == IDLE && state_n == HOLD) begin
            alu_result   <= res;
            alu_overflow <= ovf;
            illegal_op   <= ill;
        end
`ifdef ALU_MC_MUL_EN
        else if (state == MUL && &cnt) begin
            alu_result   <= acc_n[WIDTH-1:0];
            alu_overflow <= |acc_n[2*WIDTH-1:WIDTH];
            illegal_op   <= 1'b0;
        end
`endif
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] src1, src2, alu_result;
    logic         alu_overflow, illegal_op;
    int           checks = 0, failures = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic v, output logic il, output int lat);
        longint s;
        longint unsigned p;
        r = '0; v = 1'b0; il = 1'b0; lat = 1;
        case (o)
            4'd0: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b; v = s > 64'sd2147483647 || s < -64'sd2147483648; end
            4'd1: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b; v = s > 64'sd2147483647 || s < -64'sd2147483648; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a >> (b % W);
            4'd6: r = a << (b % W);
            4'd7: begin r = a; repeat (b % W) r = {r[0], r[W-1:1]}; end
            4'd8: r = a;
`ifdef ALU_MC_MUL_EN
            4'd9: begin p = longint'(a) * longint'(b); r = p[W-1:0]; v = p[2*W-1:W] != 0; lat = W + 1; end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit rel, input bit scramble,
                          output int lat, output logic [W-1:0] r, output logic v, output logic il);
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (scramble) begin
                op = 4'($urandom); src1 = $urandom; src2 = $urandom; in_valid = 1'($urandom);
            end
            tick;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) lat = -1;
        r = alu_result; v = alu_overflow; il = illegal_op;
        if (rel) begin
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; src1 = '0; src2 = '0;
        repeat (3) tick;
        reset = 1'b1;
        checks++;
        if ({out_valid, alu_result, alu_overflow, illegal_op} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b r=%h o=%b i=%b, expected all zero", out_valid, alu_result, alu_overflow, illegal_op);
        end
        tick;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [3:0]   ops [5] = '{4'd0, 4'd1, 4'd7, 4'd12, 4'd9};
        logic [W-1:0] as  [5] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'h12345678, 32'h00010000};
        logic [W-1:0] bs  [5] = '{32'h1, 32'h1, 32'h21, 32'h9ABCDEF0, 32'h00010000};
        logic [W-1:0] er  [5] = '{32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0};
        logic [W-1:0] r, mr;
        logic         v, il, mv, mil;
        int           lat, mlat;
        for (int i = 0; i < 5; i++) begin
            model(ops[i], as[i], bs[i], mr, mv, mil, mlat);
            run_op(ops[i], as[i], bs[i], 1'b1, 1'b1, lat, r, v, il);
            checks++;
            if (r !== er[i] || r !== mr || v !== mv || il !== mil || lat !== mlat) begin
                failures++;
                $display("FAIL directed_%0d: got r=%h o=%b i=%b lat=%0d, expected r=%h o=%b i=%b lat=%0d",
                         i, r, v, il, lat, mr, mv, mil, mlat);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]   o;
        logic [W-1:0] a, b, r, mr;
        logic         v, il, mv, mil;
        int           lat, mlat;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom);
            a = $urandom;
            b = (i % 3 == 0) ? W'($urandom_range(0, 70)) : $urandom;
            model(o, a, b, mr, mv, mil, mlat);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL random_ready_%0d: got in_ready=%b expected 1", i, in_ready);
            end
            run_op(o, a, b, 1'b1, 1'b1, lat, r, v, il);
            checks++;
            if (r !== mr || v !== mv || il !== mil || lat !== mlat) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got r=%h o=%b i=%b lat=%0d, expected r=%h o=%b i=%b lat=%0d",
                         i, o, a, b, r, v, il, lat, mr, mv, mil, mlat);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a, b, r, mr;
        logic         v, il, mv, mil;
        int           lat, mlat;
        a = $urandom; b = $urandom;
        model(4'd0, a, b, mr, mv, mil, mlat);
        run_op(4'd0, a, b, 1'b0, 1'b0, lat, r, v, il);
        checks++;
        if (r !== mr || v !== mv || il !== mil || lat !== mlat) begin
            failures++;
            $display("FAIL bp_result: got r=%h o=%b lat=%0d, expected r=%h o=%b lat=%0d", r, v, lat, mr, mv, mlat);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 4'($urandom); src1 = $urandom; src2 = $urandom;
            tick;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== mr || alu_overflow !== mv || illegal_op !== mil) begin
                failures++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b r=%h o=%b i=%b, expected v=1 rdy=0 r=%h o=%b i=%b",
                         i, out_valid, in_ready, alu_result, alu_overflow, illegal_op, mr, mv, mil);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== mr) begin
            failures++;
            $display("FAIL bp_release: got v=%b rdy=%b r=%h, expected v=0 rdy=1 r=%h", out_valid, in_ready, alu_result, mr);
        end
    endtask

    task automatic test_reset_inflight;
        logic [W-1:0] r;
        logic         v, il;
        int           lat, seen;
        run_op(4'd0, 32'd5, 32'd5, 1'b0, 1'b0, lat, r, v, il);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || alu_result !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold: got v=%b r=%h rdy=%b, expected v=0 r=0 rdy=1", out_valid, alu_result, in_ready);
        end
`ifdef ALU_MC_MUL_EN
        run_op(4'd0, 32'd7, 32'd7, 1'b1, 1'b0, lat, r, v, il);
        op = 4'd9; src1 = 32'hFFFF; src2 = 32'hFFFF; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || alu_result !== '0 || alu_overflow !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mul: got v=%b r=%h o=%b rdy=%b, expected v=0 r=0 o=0 rdy=1", out_valid, alu_result, alu_overflow, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mul_discard: got %0d out_valid cycles rdy=%b, expected 0 rdy=1", seen, in_ready);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_inflight;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
